// File: rtl/pipe_pkg.sv
// Shared types and default widths for the valid/ready pipeline stage registers.
package pipe_pkg;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_t;

    localparam int IF_ID_DATA_W  = 64;   // PC, Instr
    localparam int IF_ID_CTRL_W  = 1;
    localparam int ID_EX_DATA_W  = 133;  // PC, RD1, RD2, ImmExt, Rd
    localparam int ID_EX_CTRL_W  = 9;
    localparam int EX_MEM_DATA_W = 69;   // ALUResult, WriteData, Rd
    localparam int EX_MEM_CTRL_W = 4;
    localparam int MEM_WB_DATA_W = 69;   // ALUResult, ReadData, Rd
    localparam int MEM_WB_CTRL_W = 3;

endpackage

// File: rtl/stage_slot.sv
// One storage slot of a pipeline stage: register with load enable and
// synchronous clear (clear wins over load).
module stage_slot
    import pipe_pkg::*;
#(
    parameter int W = 35
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr)
            q_d = '0;
        else if (ld)
            q_d = d;
    end

    always_ff @(posedge clk) begin
        if (rst)
            q_q <= '0;
        else
            q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid
// buffer, flush, and control bits forced to zero on bubbles.
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 3,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    localparam int W = DATA_W + CTRL_W;

    stage_state_t   state_q, state_d;
    logic           push, pop;
    logic           head_ld, head_clr;
    logic [W-1:0]   head_d, head_q;

    assign out_valid = (state_q != ST_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_EMPTY;
        else
            state_q <= state_d;
    end

    generate
        if (SKID != 0) begin : g_skid
            logic         skid_ld, skid_clr;
            logic [W-1:0] skid_q;

            // Registered ready: depends on state only, never on out_ready.
            assign in_ready = (state_q != ST_TWO);

            always_comb begin
                state_d  = state_q;
                head_ld  = 1'b0;
                head_clr = 1'b0;
                skid_ld  = 1'b0;
                skid_clr = 1'b0;
                head_d   = {in_ctrl, in_data};
                if (flush) begin
                    state_d  = ST_EMPTY;
                    head_clr = 1'b1;
                    skid_clr = 1'b1;
                end else begin
                    case (state_q)
                        ST_EMPTY: if (push) begin
                            state_d = ST_ONE;
                            head_ld = 1'b1;
                        end
                        ST_ONE: begin
                            if (push && pop) begin
                                head_ld = 1'b1;
                            end else if (push) begin
                                state_d = ST_TWO;
                                skid_ld = 1'b1;
                            end else if (pop) begin
                                state_d  = ST_EMPTY;
                                head_clr = 1'b1;
                            end
                        end
                        ST_TWO: if (pop) begin
                            state_d  = ST_ONE;
                            head_ld  = 1'b1;
                            head_d   = skid_q;
                            skid_clr = 1'b1;
                        end
                        default: state_d = ST_EMPTY;
                    endcase
                end
            end

            stage_slot #(.W(W)) u_skid (
                .clk (clk),
                .rst (rst),
                .clr (skid_clr),
                .ld  (skid_ld),
                .d   ({in_ctrl, in_data}),
                .q   (skid_q)
            );
        end else begin : g_single
            assign in_ready = !out_valid | out_ready;

            always_comb begin
                state_d  = state_q;
                head_ld  = 1'b0;
                head_clr = 1'b0;
                head_d   = {in_ctrl, in_data};
                if (flush) begin
                    state_d  = ST_EMPTY;
                    head_clr = 1'b1;
                end else if (push) begin
                    state_d = ST_ONE;
                    head_ld = 1'b1;
                end else if (pop) begin
                    state_d  = ST_EMPTY;
                    head_clr = 1'b1;
                end
            end
        end
    endgenerate

    stage_slot #(.W(W)) u_head (
        .clk (clk),
        .rst (rst),
        .clr (head_clr),
        .ld  (head_ld),
        .d   (head_d),
        .q   (head_q)
    );

    assign out_ctrl = head_q[W-1:DATA_W] & {CTRL_W{out_valid}};
    assign out_data = head_q[DATA_W-1:0];
    assign count    = state_q;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: SKID=1 and SKID=0 instances on shared inputs,
// a per-instance FIFO scoreboard, a vector table and hand-written corner cases.
module tb_pipe_stage_hs;

    localparam int DW = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          ir1, ov1, ir0, ov0;
    logic [CW-1:0] oc1, oc0;
    logic [DW-1:0] od1, od0;
    logic [1:0]    cnt1, cnt0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir1), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_ctrl(oc1), .out_data(od1),
        .count(cnt1)
    );

    pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir0), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_ctrl(oc0), .out_data(od0),
        .count(cnt0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboards: entries pushed on accepted handshakes, popped on consumption.
    logic [CW+DW-1:0] q1[$];
    logic [CW+DW-1:0] q0[$];

    always @(negedge clk) begin
        chk("sb1_count", {30'd0, cnt1}, q1.size());
        chk("sb1_out_valid", {31'd0, ov1}, {31'd0, q1.size() != 0});
        chk("sb1_in_ready", {31'd0, ir1}, {31'd0, q1.size() < 2});
        if (!ov1) chk("sb1_bubble_ctrl", {29'd0, oc1}, 32'd0);
        chk("sb0_count", {30'd0, cnt0}, q0.size());
        chk("sb0_out_valid", {31'd0, ov0}, {31'd0, q0.size() != 0});
        chk("sb0_in_ready", {31'd0, ir0}, {31'd0, (q0.size() == 0) || out_ready});
        if (!ov0) chk("sb0_bubble_ctrl", {29'd0, oc0}, 32'd0);

        if (rst || flush) begin
            q1.delete();
            q0.delete();
        end else begin
            if (ov1 && out_ready && q1.size() != 0)
                chk("sb1_order", {21'd0, oc1, od1}, {21'd0, q1.pop_front()});
            if (in_valid && ir1)
                q1.push_back({in_ctrl, in_data});
            if (ov0 && out_ready && q0.size() != 0)
                chk("sb0_order", {21'd0, oc0, od0}, {21'd0, q0.pop_front()});
            if (in_valid && ir0)
                q0.push_back({in_ctrl, in_data});
        end
    end

    typedef struct {
        logic          iv;
        logic [CW-1:0] ic;
        logic [DW-1:0] id;
        logic          ordy;
        logic          fl;
        logic          ov;
        logic [CW-1:0] oc;
        logic [DW-1:0] od;
        logic [1:0]    cnt;
        logic          ir;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                                input logic ordy, input logic fl, input logic ov,
                                input logic [CW-1:0] oc, input logic [DW-1:0] od,
                                input logic [1:0] cnt, input logic ir);
        vec_t v;
        v.iv = iv; v.ic = ic; v.id = id; v.ordy = ordy; v.fl = fl;
        v.ov = ov; v.oc = oc; v.od = od; v.cnt = cnt; v.ir = ir;
        return v;
    endfunction

    vec_t vt[18];

    initial begin
        // Expected SKID=1 outputs after the edge at which each vector is applied.
        //          iv  ic    id     ordy fl  ov  oc    od     cnt ir
        vt[0]  = mk(1, 3'd5, 8'h11, 1, 0,  1, 3'd5, 8'h11, 1,  1);
        vt[1]  = mk(1, 3'd5, 8'h12, 1, 0,  1, 3'd5, 8'h12, 1,  1);
        vt[2]  = mk(1, 3'd5, 8'h13, 1, 0,  1, 3'd5, 8'h13, 1,  1);
        vt[3]  = mk(1, 3'd5, 8'h14, 1, 0,  1, 3'd5, 8'h14, 1,  1);
        vt[4]  = mk(1, 3'd5, 8'h15, 1, 0,  1, 3'd5, 8'h15, 1,  1);
        vt[5]  = mk(0, 3'd7, 8'h77, 1, 0,  0, 3'd0, 8'h00, 0,  1);
        vt[6]  = mk(0, 3'd7, 8'h78, 1, 0,  0, 3'd0, 8'h00, 0,  1);
        vt[7]  = mk(1, 3'd1, 8'h0A, 0, 0,  1, 3'd1, 8'h0A, 1,  1);
        vt[8]  = mk(1, 3'd2, 8'h0B, 0, 0,  1, 3'd1, 8'h0A, 2,  0);
        vt[9]  = mk(1, 3'd3, 8'h0C, 0, 0,  1, 3'd1, 8'h0A, 2,  0);
        vt[10] = mk(1, 3'd3, 8'h0C, 1, 0,  1, 3'd2, 8'h0B, 1,  1);
        vt[11] = mk(1, 3'd3, 8'h0C, 0, 0,  1, 3'd2, 8'h0B, 2,  0);
        vt[12] = mk(0, 3'd0, 8'h00, 1, 0,  1, 3'd3, 8'h0C, 1,  1);
        vt[13] = mk(0, 3'd0, 8'h00, 1, 0,  0, 3'd0, 8'h00, 0,  1);
        vt[14] = mk(1, 3'd6, 8'h21, 0, 0,  1, 3'd6, 8'h21, 1,  1);
        vt[15] = mk(1, 3'd6, 8'h22, 0, 0,  1, 3'd6, 8'h21, 2,  0);
        vt[16] = mk(1, 3'd7, 8'hDD, 0, 1,  0, 3'd0, 8'h00, 0,  1);
        vt[17] = mk(0, 3'd0, 8'h00, 1, 0,  0, 3'd0, 8'h00, 0,  1);

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready_during", {31'd0, ir1}, 32'd1);
        rst = 1'b0;
        chk("rst_out_valid", {31'd0, ov1}, 32'd0);
        chk("rst_out_ctrl", {29'd0, oc1}, 32'd0);
        chk("rst_out_data", {24'd0, od1}, 32'd0);
        chk("rst_count", {30'd0, cnt1}, 32'd0);
        chk("rst_out_data_s0", {24'd0, od0}, 32'd0);

        for (int i = 0; i < 18; i++) begin
            in_valid = vt[i].iv; in_ctrl = vt[i].ic; in_data = vt[i].id;
            out_ready = vt[i].ordy; flush = vt[i].fl;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", i), {31'd0, ov1}, {31'd0, vt[i].ov});
            chk($sformatf("vec%0d_out_ctrl", i), {29'd0, oc1}, {29'd0, vt[i].oc});
            chk($sformatf("vec%0d_count", i), {30'd0, cnt1}, {30'd0, vt[i].cnt});
            chk($sformatf("vec%0d_in_ready", i), {31'd0, ir1}, {31'd0, vt[i].ir});
            if (vt[i].ov)
                chk($sformatf("vec%0d_out_data", i), {24'd0, od1}, {24'd0, vt[i].od});
        end
        flush = 1'b0;

        // SKID=0: full slot with out_ready low blocks, raising it frees the slot combinationally.
        in_valid = 1'b1; in_ctrl = 3'd2; in_data = 8'h31; out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("s0_fill_count", {30'd0, cnt0}, 32'd1);
        chk("s0_fill_data", {24'd0, od0}, 32'h31);
        in_data = 8'h32;
        #1;
        chk("s0_full_in_ready", {31'd0, ir0}, 32'd0);
        out_ready = 1'b1;
        #1;
        chk("s0_comb_in_ready", {31'd0, ir0}, 32'd1);
        @(posedge clk);
        #1;
        chk("s0_pushpop_count", {30'd0, cnt0}, 32'd1);
        chk("s0_pushpop_data", {24'd0, od0}, 32'h32);

        // Reset while SKID=1 holds two entries and a pop is pending.
        in_data = 8'h41; out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_pre_count", {30'd0, cnt1}, 32'd2);
        rst = 1'b1; out_ready = 1'b1; in_data = 8'h43;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", {31'd0, ov1}, 32'd0);
        chk("midrst_out_ctrl", {29'd0, oc1}, 32'd0);
        chk("midrst_out_data", {24'd0, od1}, 32'd0);
        chk("midrst_count", {30'd0, cnt1}, 32'd0);
        chk("midrst_in_ready", {31'd0, ir1}, 32'd1);
        chk("midrst_out_data_s0", {24'd0, od0}, 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_hs.md
# pipe_stage_hs

Parametrised pipeline stage register with a valid/ready handshake, optional 2-entry skid buffer, and synchronous flush. It is the successor to the fixed-field inter-stage registers of the RISC-V pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque payload plus a control-bit field that is forced to zero on bubbles, so RegWrite/MemWrite-style bits can never leak from an empty slot. Stalls propagate backpressure instead of relying on global enables.

## Interface
- `DATA_W`, default 32: payload width (concatenated datapath fields, e.g. ALUResult, ReadData, Rd).
- `CTRL_W`, default 3: control field width (e.g. RegWrite + ResultSrc). Zeroed whenever the slot is invalid.
- `SKID`, default 1: 1 = 2-entry skid buffer with registered `in_ready`; 0 = single register with combinational ready.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous kill of all held entries (branch mispredict / exception).
- `in_valid` in 1: upstream holds a valid entry.
- `in_ready` out 1: stage accepts an entry this cycle.
- `in_ctrl` in CTRL_W: upstream control bits.
- `in_data` in DATA_W: upstream payload.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: downstream consumes the head this cycle.
- `out_ctrl` out CTRL_W: head control bits; 0 when `out_valid`=0.
- `out_data` out DATA_W: head payload; value is don't-care when `out_valid`=0.
- `count` out 2: entries held (0..2; max 1 when SKID=0).

## Operation
- push = `in_valid & in_ready`; pop = `out_valid & out_ready`.
- SKID=1 state machine (states in `count`):
  - EMPTY: push goes to ONE, with the head loaded from the input.
  - ONE: push & pop stays ONE, with the head loaded from the input. Push only goes to TWO, with the skid loaded from the input. Pop only goes to EMPTY.
  - TWO: `in_ready`=0. Pop goes to ONE, with head ← skid. No pop stays TWO.
- SKID=1 ready and valid: `in_ready` = (state != TWO), a function of state only, with no combinational path from `out_ready`. `out_valid` = (state != EMPTY).
- SKID=0 behaviour:
  - Single slot; `in_ready` = !`out_valid` | `out_ready`.
  - Push loads the slot.
  - Pop without push empties it.
- Ordering: strict FIFO; the skid entry is never emitted before the head.
- Flush:
  - Next state is EMPTY and `out_ctrl` becomes 0.
  - Any same-cycle push is discarded; flush has priority over push and pop.
  - Payload registers need not be cleared.
- Reset: identical to flush, and additionally clears all payload and control registers to 0.
- Control masking: held control registers are cleared when their slot empties. `out_ctrl` is additionally ANDed with `out_valid`.

## Timing
- Latency: 1 cycle. An entry pushed at edge N is visible on `out_*` after edge N.
- Throughput: 1 entry/cycle sustained when `out_ready`=1, in both SKID modes.
- Outputs after reset: `out_valid`=0, `out_ctrl`=0, `out_data`=0, `count`=0. `in_ready`=1 from the first cycle after reset, and also while `rst` is high (state EMPTY).
- Downstream stall: a single-cycle stall with SKID=1 loses no bubble and no data. Upstream sees `in_ready`=0 only after two entries are buffered.
- Flush and `rst` take effect at the edge where they are sampled. `out_valid` is low in the following cycle.

## Structure
- Shared package `pipe_pkg`:
  - `stage_state_t` enum {ST_EMPTY, ST_ONE, ST_TWO}, 2-bit encoding equal to `count`.
  - Default width constants for the four RISC-V stage instances.
- Sub-module `stage_slot`: a DATA_W+CTRL_W register with load enable and synchronous clear. It is instantiated twice for SKID=1 (head, skid) and once for SKID=0.
- Mode selection is by a generate on `SKID`.

## Test plan
- Reset then stream: hold `rst` 2 cycles, then push data 0x11..0x15 with ctrl 3'b101 and `out_ready`=1.
  - 0x11 appears one cycle after its push.
  - One output per cycle, in order.
  - `count`=1 throughout.
- Backpressure (SKID=1): push 0xA, 0xB, 0xC on consecutive cycles with `out_ready`=0.
  - `count` goes 1 → 2.
  - `in_ready`=0 once `count`=2, so 0xC is held upstream.
  - Raise `out_ready`: outputs A, B, C in order with no loss.
- Flush with simultaneous push: with `count`=2, assert `flush` and `in_valid` (0xDD) in the same cycle.
  - Next cycle: `out_valid`=0, `out_ctrl`=0, `count`=0.
  - 0xDD is never output.
- Bubble masking: `in_valid`=0 while `in_ctrl`=3'b111.
  - `out_ctrl` stays 0 and `out_valid`=0.
- SKID=0 instance: `out_ready`=0 with the slot full.
  - `in_ready`=0 in the same cycle.
  - Toggling `out_ready` to 1 raises `in_ready` combinationally; push and pop in one cycle keep `count`=1.
- Reset mid-operation: assert `rst` while `count`=2 and a pop is pending.
  - Next cycle: all outputs 0, `in_ready`=1.
